// File: rtl/dds_sweep_if.sv
// Config/control bundle between the sweep sequencer and its controller.
// master drives start/abort; slave (the sequencer) drives the DDS config side.
interface dds_sweep_if;
    logic        i_start;
    logic        i_abort;
    logic [15:0] o_pinc;
    logic [15:0] o_poff;
    logic        o_cfg_valid;
    logic        o_running;
    logic        o_done;
    logic [15:0] o_step_idx;

    modport master (
        output i_start, i_abort,
        input  o_pinc, o_poff, o_cfg_valid, o_running, o_done, o_step_idx
    );

    modport slave (
        input  i_start, i_abort,
        output o_pinc, o_poff, o_cfg_valid, o_running, o_done, o_step_idx
    );
endinterface

// File: rtl/dds_sweep_ctrl.sv
// DDS frequency-sweep sequencer: steps the phase increment START->STOP (optionally back down).
// Define DDS_SWEEP_CONTINUOUS_EN to restart the sweep after every completion until abort/reset.
module dds_sweep_ctrl #(
    parameter logic [15:0] START_FREQ   = 16'h1000,
    parameter logic [15:0] STOP_FREQ    = 16'hF000,
    parameter logic [15:0] STEP         = 16'h0100,
    parameter int unsigned DWELL_CYCLES = 50_000,
    parameter string       MODE         = "linear",
    parameter logic [15:0] POFF         = 16'h0000
) (
    input  logic       clk,
    input  logic       rst,
    dds_sweep_if.slave bus,
    output logic [2:0] o_dbg_state
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_DWELL  = 3'd2;
    localparam logic [2:0] S_STEP   = 3'd3;
    localparam logic [2:0] S_FINISH = 3'd4;

    localparam bit          TRIANGLE     = (MODE == "triangle");
    localparam logic [31:0] DWELL_RELOAD = DWELL_CYCLES - 32'd1;

`ifdef DDS_SWEEP_CONTINUOUS_EN
    localparam bit CONTINUOUS = 1'b1;
`else
    localparam bit CONTINUOUS = 1'b0;
`endif

    logic [2:0]  r_state;
    logic [15:0] r_pinc;
    logic [15:0] r_step_idx;
    logic [31:0] r_cnt;
    logic        r_cfg_valid;
    logic        r_running;
    logic        r_done;
    logic        r_final;
    logic        r_down;

    logic [16:0]        w_sum;
    logic signed [16:0] w_diff;
    logic               w_up_peak;
    logic               w_dn_end;
    logic [15:0]        w_next_pinc;
    logic               w_next_final;
    logic               w_next_down;
    logic               w_load;

    // 17-bit arithmetic so the clamp decisions see the carry/borrow instead of a wrapped value.
    assign w_sum     = {1'b0, r_pinc} + {1'b0, STEP};
    assign w_diff    = $signed({1'b0, r_pinc}) - $signed({1'b0, STEP});
    assign w_up_peak = (w_sum >= {1'b0, STOP_FREQ});
    assign w_dn_end  = (w_diff <= $signed({1'b0, START_FREQ}));

    always_comb begin
        w_next_pinc  = r_pinc;
        w_next_final = 1'b0;
        w_next_down  = r_down;
        if (r_down) begin
            if (w_dn_end) begin
                w_next_pinc  = START_FREQ;
                w_next_final = 1'b1;
            end else begin
                w_next_pinc = w_diff[15:0];
            end
        end else if (w_up_peak) begin
            w_next_pinc = STOP_FREQ;
            if (TRIANGLE) w_next_down = 1'b1;
            else          w_next_final = 1'b1;
        end else begin
            w_next_pinc = w_sum[15:0];
        end
    end

    // FINISH re-enters LOAD directly in continuous builds; abort always takes priority.
    assign w_load = !bus.i_abort &&
                    ((r_state == S_IDLE && bus.i_start) || (r_state == S_FINISH && CONTINUOUS));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_pinc      <= START_FREQ;
            r_step_idx  <= '0;
            r_cnt       <= '0;
            r_cfg_valid <= 1'b0;
            r_running   <= 1'b0;
            r_done      <= 1'b0;
            r_final     <= 1'b0;
            r_down      <= 1'b0;
        end else begin
            r_cfg_valid <= 1'b0;
            r_done      <= 1'b0;
            if (w_load) begin
                r_state     <= S_LOAD;
                r_pinc      <= START_FREQ;
                r_step_idx  <= '0;
                r_cnt       <= DWELL_RELOAD;
                r_final     <= (START_FREQ == STOP_FREQ);
                r_down      <= 1'b0;
                r_cfg_valid <= 1'b1;
                r_running   <= 1'b1;
            end else if (r_state != S_IDLE && bus.i_abort) begin
                r_state   <= S_IDLE;
                r_running <= 1'b0;
            end else begin
                case (r_state)
                    // The strobe cycle counts as the first dwell cycle.
                    S_LOAD, S_STEP, S_DWELL: begin
                        if (r_cnt == '0) begin
                            if (r_final) begin
                                r_state   <= S_FINISH;
                                r_done    <= 1'b1;
                                r_running <= CONTINUOUS;
                            end else begin
                                r_state     <= S_STEP;
                                r_pinc      <= w_next_pinc;
                                r_final     <= w_next_final;
                                r_down      <= w_next_down;
                                r_step_idx  <= r_step_idx + 16'd1;
                                r_cnt       <= DWELL_RELOAD;
                                r_cfg_valid <= 1'b1;
                            end
                        end else begin
                            r_state <= S_DWELL;
                            r_cnt   <= r_cnt - 32'd1;
                        end
                    end
                    S_FINISH: begin
                        r_state   <= S_IDLE;
                        r_running <= 1'b0;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.o_pinc      = r_pinc;
    assign bus.o_poff      = POFF;
    assign bus.o_cfg_valid = r_cfg_valid;
    assign bus.o_running   = r_running;
    assign bus.o_done      = r_done;
    assign bus.o_step_idx  = r_step_idx;
    assign o_dbg_state     = r_state;
endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Bench for dds_sweep_ctrl: four parameterisations checked every cycle against a
// schedule-based model (strobe k at t0 + k*DWELL, done at t0 + N*DWELL).
module tb_dds_sweep_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

`ifdef DDS_SWEEP_CONTINUOUS_EN
  localparam bit CONT = 1'b1;
`else
  localparam bit CONT = 1'b0;
`endif

  // Configurations: basic linear, clamped linear, overflow clamp, triangle.
  int cfg_start[4] = '{32'h1000, 32'h1000, 32'hF000, 32'h1000};
  int cfg_stop [4] = '{32'h1300, 32'h1250, 32'hFFFF, 32'h1300};
  int cfg_step [4] = '{32'h0100, 32'h0100, 32'h8000, 32'h0100};
  int cfg_dwell[4] = '{4, 4, 2, 4};
  bit cfg_tri  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
  int cfg_poff [4] = '{32'h0000, 32'h1234, 32'hABCD, 32'h0F0F};

  logic [3:0]  drv_start = '0;
  logic [3:0]  drv_abort = '0;
  logic [15:0] ob_pinc[4];
  logic [15:0] ob_poff[4];
  logic [15:0] ob_idx[4];
  logic        ob_cfg[4];
  logic        ob_run[4];
  logic        ob_done[4];
  logic [2:0]  ob_dbg[4];

  dds_sweep_if if0 ();
  dds_sweep_if if1 ();
  dds_sweep_if if2 ();
  dds_sweep_if if3 ();

  dds_sweep_ctrl #(.START_FREQ(16'h1000), .STOP_FREQ(16'h1300), .STEP(16'h0100),
                   .DWELL_CYCLES(4), .MODE("linear"), .POFF(16'h0000))
    u_dut0 (.clk(clk), .rst(rst), .bus(if0.slave), .o_dbg_state(ob_dbg[0]));
  dds_sweep_ctrl #(.START_FREQ(16'h1000), .STOP_FREQ(16'h1250), .STEP(16'h0100),
                   .DWELL_CYCLES(4), .MODE("linear"), .POFF(16'h1234))
    u_dut1 (.clk(clk), .rst(rst), .bus(if1.slave), .o_dbg_state(ob_dbg[1]));
  dds_sweep_ctrl #(.START_FREQ(16'hF000), .STOP_FREQ(16'hFFFF), .STEP(16'h8000),
                   .DWELL_CYCLES(2), .MODE("linear"), .POFF(16'hABCD))
    u_dut2 (.clk(clk), .rst(rst), .bus(if2.slave), .o_dbg_state(ob_dbg[2]));
  dds_sweep_ctrl #(.START_FREQ(16'h1000), .STOP_FREQ(16'h1300), .STEP(16'h0100),
                   .DWELL_CYCLES(4), .MODE("triangle"), .POFF(16'h0F0F))
    u_dut3 (.clk(clk), .rst(rst), .bus(if3.slave), .o_dbg_state(ob_dbg[3]));

  assign if0.i_start = drv_start[0];  assign if0.i_abort = drv_abort[0];
  assign if1.i_start = drv_start[1];  assign if1.i_abort = drv_abort[1];
  assign if2.i_start = drv_start[2];  assign if2.i_abort = drv_abort[2];
  assign if3.i_start = drv_start[3];  assign if3.i_abort = drv_abort[3];

  assign ob_pinc[0] = if0.o_pinc;  assign ob_poff[0] = if0.o_poff;  assign ob_idx[0] = if0.o_step_idx;
  assign ob_pinc[1] = if1.o_pinc;  assign ob_poff[1] = if1.o_poff;  assign ob_idx[1] = if1.o_step_idx;
  assign ob_pinc[2] = if2.o_pinc;  assign ob_poff[2] = if2.o_poff;  assign ob_idx[2] = if2.o_step_idx;
  assign ob_pinc[3] = if3.o_pinc;  assign ob_poff[3] = if3.o_poff;  assign ob_idx[3] = if3.o_step_idx;
  assign ob_cfg[0] = if0.o_cfg_valid;  assign ob_run[0] = if0.o_running;  assign ob_done[0] = if0.o_done;
  assign ob_cfg[1] = if1.o_cfg_valid;  assign ob_run[1] = if1.o_running;  assign ob_done[1] = if1.o_done;
  assign ob_cfg[2] = if2.o_cfg_valid;  assign ob_run[2] = if2.o_running;  assign ob_done[2] = if2.o_done;
  assign ob_cfg[3] = if3.o_cfg_valid;  assign ob_run[3] = if3.o_running;  assign ob_done[3] = if3.o_done;

  // Reference model state
  int m_seq[4][$];
  bit m_act[4];
  int m_t0[4];
  int m_hold_pinc[4];
  int m_hold_idx[4];
  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Frequency list from the ramp rules, in plain integer arithmetic.
  task automatic build_seq(input int d);
    int f;
    f = cfg_start[d];
    m_seq[d].delete();
    m_seq[d].push_back(f);
    if (cfg_start[d] != cfg_stop[d]) begin
      while (f < cfg_stop[d]) begin
        f = (f + cfg_step[d] > cfg_stop[d]) ? cfg_stop[d] : f + cfg_step[d];
        m_seq[d].push_back(f);
      end
      if (cfg_tri[d]) begin
        while (f > cfg_start[d]) begin
          f = (f - cfg_step[d] < cfg_start[d]) ? cfg_start[d] : f - cfg_step[d];
          m_seq[d].push_back(f);
        end
      end
    end
  endtask

  task automatic exp_now(input int d, output int pinc, output int idx,
                         output bit cfg, output bit run, output bit done);
    int e, n, dw, k;
    pinc = m_hold_pinc[d]; idx = m_hold_idx[d]; cfg = 0; run = 0; done = 0;
    if (m_act[d]) begin
      e = cyc - m_t0[d]; n = m_seq[d].size(); dw = cfg_dwell[d];
      if (e < n * dw) begin
        k = e / dw;
        pinc = m_seq[d][k]; idx = k; cfg = (e % dw == 0); run = 1;
      end else begin
        pinc = m_seq[d][n-1]; idx = n - 1; done = 1; run = CONT;
      end
    end
  endtask

  task automatic model_step(input logic r, input logic [3:0] s, input logic [3:0] a);
    int pinc, idx; bit cfg, run, done;
    for (int d = 0; d < 4; d++) begin
      if (r) begin
        m_act[d] = 0; m_hold_pinc[d] = cfg_start[d]; m_hold_idx[d] = 0;
      end else if (!m_act[d]) begin
        if (s[d] && !a[d]) begin m_act[d] = 1; m_t0[d] = cyc + 1; end
      end else begin
        exp_now(d, pinc, idx, cfg, run, done);
        m_hold_pinc[d] = pinc; m_hold_idx[d] = idx;
        if (a[d]) m_act[d] = 0;
        else if (done) begin
          if (CONT) m_t0[d] = cyc + 1;
          else m_act[d] = 0;
        end
      end
    end
  endtask

  task automatic check_outputs();
    int pinc, idx; bit cfg, run, done;
    for (int d = 0; d < 4; d++) begin
      exp_now(d, pinc, idx, cfg, run, done);
      check($sformatf("dut%0d pinc", d), {16'h0, ob_pinc[d]}, pinc);
      check($sformatf("dut%0d poff", d), {16'h0, ob_poff[d]}, cfg_poff[d]);
      check($sformatf("dut%0d step_idx", d), {16'h0, ob_idx[d]}, idx);
      check($sformatf("dut%0d cfg_valid", d), {31'h0, ob_cfg[d]}, {31'h0, cfg});
      check($sformatf("dut%0d running", d), {31'h0, ob_run[d]}, {31'h0, run});
      check($sformatf("dut%0d done", d), {31'h0, ob_done[d]}, {31'h0, done});
      check($sformatf("dut%0d busy", d), {31'h0, (ob_dbg[d] != 3'd0)}, {31'h0, m_act[d]});
    end
  endtask

  task automatic run_cycle(input logic r, input logic [3:0] s, input logic [3:0] a);
    rst = r; drv_start = s; drv_abort = a;
    @(negedge clk);
    check_outputs();
    model_step(r, s, a);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) run_cycle(1'b0, 4'h0, 4'h0);
  endtask

  initial begin
    for (int d = 0; d < 4; d++) begin
      build_seq(d);
      m_act[d] = 0; m_t0[d] = 0; m_hold_pinc[d] = cfg_start[d]; m_hold_idx[d] = 0;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Full sweeps, then start+abort together, abort in 2nd dwell, reset in 3rd dwell.
    idle(2);
    run_cycle(1'b0, 4'hF, 4'h0);
    idle(40);
    run_cycle(1'b0, 4'h0, 4'hF);
    idle(2);
    run_cycle(1'b0, 4'hF, 4'hF);
    idle(3);
    run_cycle(1'b0, 4'hF, 4'h0);
    idle(5);
    run_cycle(1'b0, 4'h0, 4'hF);
    idle(4);
    run_cycle(1'b0, 4'hF, 4'h0);
    idle(9);
    run_cycle(1'b1, 4'h0, 4'h0);
    idle(3);

    for (int i = 0; i < 2000; i++) begin
      logic [3:0] s, a;
      logic r;
      for (int d = 0; d < 4; d++) begin
        s[d] = ($urandom_range(0, 9) == 0);
        a[d] = ($urandom_range(0, 59) == 0);
      end
      r = ($urandom_range(0, 299) == 0);
      run_cycle(r, s, a);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
